// File: rtl/tetris_pkg.sv
// Shared constants, types and cell helpers for the tetris playfield store.
package tetris_pkg;

    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int KIND_W = 4;
    localparam int CRD_W  = 5;

    typedef logic [KIND_W-1:0]      kind_t;
    typedef logic [CRD_W-1:0]       crd_t;
    typedef logic [COLS*KIND_W-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE,
        LOCK,
        SCAN,
        SHIFT,
        DONE
    } board_state_e;

    // Kind stored at column x of a row; columns past the right edge read as empty.
    function automatic kind_t cell_of(row_t row, crd_t x);
        kind_t k;
        k = '0;
        for (int c = 0; c < COLS; c++) begin
            if (x == crd_t'(c)) k = row[c*KIND_W +: KIND_W];
        end
        return k;
    endfunction

    function automatic logic row_full(row_t row);
        logic f;
        f = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (row[c*KIND_W +: KIND_W] == '0) f = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/tetris_board_if.sv
// Game-logic side of the playfield: falling piece, lock handshake and collision query.
interface tetris_board_if;
    import tetris_pkg::*;

    logic         piece_valid;
    kind_t        piece_kind;
    crd_t [3:0]   piece_x;
    crd_t [3:0]   piece_y;
    crd_t [3:0]   occ_x;
    crd_t [3:0]   occ_y;
    logic         occ_hit;
    logic         lock_valid;
    logic         lock_ready;
    logic         clear_done;
    logic [2:0]   lines_cleared;

    modport master (
        output piece_valid, piece_kind, piece_x, piece_y, occ_x, occ_y, lock_valid,
        input  occ_hit, lock_ready, clear_done, lines_cleared
    );

    modport slave (
        input  piece_valid, piece_kind, piece_x, piece_y, occ_x, occ_y, lock_valid,
        output occ_hit, lock_ready, clear_done, lines_cleared
    );

endinterface

// File: rtl/tetris_board_bcd_add_sat.sv
// Four-digit BCD plus a small binary value, carry rippled through all digits, clamps at 9999.
module bcd_add_sat (
    input  logic [15:0] i_bcd,
    input  logic [2:0]  i_val,
    output logic [15:0] o_sum
);

    logic [2:0]  w_carry;
    logic [4:0]  w_tmp;
    logic [15:0] w_sum;

    // Digit-serial add, least significant digit first; a carry out of the top digit saturates.
    always_comb begin
        w_carry = i_val;
        w_tmp   = '0;
        w_sum   = '0;
        for (int d = 0; d < 4; d++) begin
            w_tmp = {1'b0, i_bcd[d*4 +: 4]} + {2'b00, w_carry};
            if (w_tmp > 5'd9) begin
                w_sum[d*4 +: 4] = 4'(w_tmp - 5'd10);
                w_carry         = 3'd1;
            end else begin
                w_sum[d*4 +: 4] = w_tmp[3:0];
                w_carry         = 3'd0;
            end
        end
        o_sum = (w_carry != 3'd0) ? 16'h9999 : w_sum;
    end

endmodule

// File: rtl/tetris_board.sv
// Playfield store: display lookup with piece overlay, collision query, lock with row clearing.
// Optional feature: define TETRIS_BOARD_SCORE_EN to keep the BCD score; otherwise score reads 0.
//
// state | meaning
// IDLE  | waiting for a lock request; falling piece overlaid on the display
// LOCK  | write the four piece cells, start scanning at the bottom row
// SCAN  | test row r for fullness, walk upward
// SHIFT | drop rows above r by one, empty top row, rescan r
// DONE  | pulse clear_done, publish lines cleared, update score
module tetris_board
    import tetris_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  crd_t        i_disp_x,
    input  crd_t        i_disp_y,
    output kind_t       o_disp_kind,
    input  logic        i_clear_board,
    output logic [15:0] o_tetris_score,
    tetris_board_if.slave bus
);

    board_state_e r_state;
    row_t         r_board [ROWS];
    crd_t         r_row;
    logic [2:0]   r_cnt;
    kind_t        r_disp_kind;
    logic         r_occ_hit;
    logic         r_clear_done;
    logic [2:0]   r_lines;
    kind_t        w_disp_kind;
    logic         w_occ_hit;

`ifdef TETRIS_BOARD_SCORE_EN
    logic [15:0]  r_score;
    logic [15:0]  w_score_sum;

    bcd_add_sat u_score_add (
        .i_bcd (r_score),
        .i_val (r_cnt),
        .o_sum (w_score_sum)
    );

    assign o_tetris_score = r_score;
`else
    assign o_tetris_score = 16'h0000;
`endif

    assign o_disp_kind       = r_disp_kind;
    assign bus.occ_hit       = r_occ_hit;
    assign bus.lock_ready    = (r_state == IDLE);
    assign bus.clear_done    = r_clear_done;
    assign bus.lines_cleared = r_lines;

    // Display cell lookup; the piece is only drawn while the board is idle.
    always_comb begin
        w_disp_kind = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (i_disp_y == crd_t'(r)) w_disp_kind = cell_of(r_board[r], i_disp_x);
        end
        if (bus.piece_valid && r_state == IDLE &&
            i_disp_x < crd_t'(COLS) && i_disp_y < crd_t'(ROWS)) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.piece_x[i] == i_disp_x && bus.piece_y[i] == i_disp_y)
                    w_disp_kind = bus.piece_kind;
            end
        end
    end

    // Collision query against current contents; off-board cells always collide.
    always_comb begin
        w_occ_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.occ_x[i] >= crd_t'(COLS) || bus.occ_y[i] >= crd_t'(ROWS)) begin
                w_occ_hit = 1'b1;
            end else begin
                for (int r = 0; r < ROWS; r++) begin
                    if (bus.occ_y[i] == crd_t'(r) && cell_of(r_board[r], bus.occ_x[i]) != '0)
                        w_occ_hit = 1'b1;
                end
            end
        end
    end

    // Register the display and collision answers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_disp_kind <= '0;
            r_occ_hit   <= 1'b0;
        end else begin
            r_disp_kind <= w_disp_kind;
            r_occ_hit   <= w_occ_hit;
        end
    end

    // Lock / scan / shift sequencer; new game behaves like reset for board, score and status.
    always_ff @(posedge clk) begin
        if (!reset_n || i_clear_board) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_cnt        <= '0;
            r_clear_done <= 1'b0;
            r_lines      <= '0;
            for (int r = 0; r < ROWS; r++) r_board[r] <= '0;
`ifdef TETRIS_BOARD_SCORE_EN
            r_score      <= '0;
`endif
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.lock_valid) r_state <= LOCK;
                end
                LOCK: begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            for (int i = 0; i < 4; i++)
                                if (bus.piece_y[i] == crd_t'(r) && bus.piece_x[i] == crd_t'(c))
                                    r_board[r][c*KIND_W +: KIND_W] <= bus.piece_kind;
                    r_row   <= crd_t'(ROWS - 1);
                    r_cnt   <= '0;
                    r_state <= SCAN;
                end
                SCAN: begin
                    if (row_full(r_board[r_row])) r_state <= SHIFT;
                    else if (r_row == '0)        r_state <= DONE;
                    else                          r_row   <= r_row - crd_t'(1);
                end
                SHIFT: begin
                    for (int r = 1; r < ROWS; r++)
                        if (crd_t'(r) <= r_row) r_board[r] <= r_board[r-1];
                    r_board[0] <= '0;
                    r_cnt      <= r_cnt + 3'd1;
                    r_state    <= SCAN;
                end
                DONE: begin
                    r_clear_done <= 1'b1;
                    r_lines      <= r_cnt;
`ifdef TETRIS_BOARD_SCORE_EN
                    r_score      <= w_score_sum;
`endif
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_board.sv
module tb_tetris_board;
    import tetris_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    crd_t        disp_x, disp_y;
    kind_t       disp_kind;
    logic        clear_board;
    logic [15:0] score;

    logic [15:0] bcd_in, bcd_out;
    logic [2:0]  bcd_val;

    always #5 clk = ~clk;

    tetris_board_if bus ();

    tetris_board dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_disp_x       (disp_x),
        .i_disp_y       (disp_y),
        .o_disp_kind    (disp_kind),
        .i_clear_board  (clear_board),
        .o_tetris_score (score),
        .bus            (bus)
    );

    bcd_add_sat u_bcd (
        .i_bcd (bcd_in),
        .i_val (bcd_val),
        .o_sum (bcd_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int m_board [ROWS][COLS];
    int m_score;
    int m_lines;
    int p_x [4];
    int p_y [4];
    int q_x [4];
    int q_y [4];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic int exp_score();
`ifdef TETRIS_BOARD_SCORE_EN
        return to_bcd(m_score > 9999 ? 9999 : m_score);
`else
        return 0;
`endif
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_board[r][c] = 0;
        m_score = 0;
        m_lines = 0;
    endtask

    // Drop the piece in, then remove every full row and let the rest fall, counting removals.
    task automatic model_lock(input int kind);
        int nb [ROWS][COLS];
        int w;
        bit full;
        for (int i = 0; i < 4; i++)
            if (p_x[i] < COLS && p_y[i] < ROWS) m_board[p_y[i]][p_x[i]] = kind;
        w = ROWS - 1;
        m_lines = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1;
            for (int c = 0; c < COLS; c++) if (m_board[r][c] == 0) full = 0;
            if (full) m_lines++;
            else begin
                for (int c = 0; c < COLS; c++) nb[w][c] = m_board[r][c];
                w--;
            end
        end
        for (int r = w; r >= 0; r--)
            for (int c = 0; c < COLS; c++) nb[r][c] = 0;
        m_board = nb;
        m_score += m_lines;
    endtask

    function automatic int exp_disp(input int x, input int y, input bit pv, input int pk);
        if (x >= COLS || y >= ROWS) return 0;
        if (pv)
            for (int i = 0; i < 4; i++)
                if (p_x[i] == x && p_y[i] == y) return pk;
        return m_board[y][x];
    endfunction

    task automatic set_piece(input int kind, input bit pv);
        bus.piece_kind  = kind_t'(kind);
        bus.piece_valid = pv;
        for (int i = 0; i < 4; i++) begin
            bus.piece_x[i] = crd_t'(p_x[i]);
            bus.piece_y[i] = crd_t'(p_y[i]);
        end
    endtask

    task automatic do_lock(input int kind);
        int n;
        int lat;
        bit seen;
        @(negedge clk);
        set_piece(kind, 1'b1);
        bus.lock_valid = 1'b1;
        check("lock_ready_idle", int'(bus.lock_ready), 1);
        @(posedge clk);
        @(negedge clk);
        bus.lock_valid = 1'b0;
        check("lock_ready_busy", int'(bus.lock_ready), 0);
        model_lock(kind);
        lat  = 2 + ROWS + 2 * m_lines;
        n    = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.clear_done) seen = 1;
        end
        check("done_latency", n, lat);
        check("lines_cleared", int'(bus.lines_cleared), m_lines);
        check("score", int'(score), exp_score());
        @(posedge clk);
        #1;
        check("done_pulse", int'(bus.clear_done), 0);
        @(negedge clk);
        bus.piece_valid = 1'b0;
    endtask

    task automatic read_disp(input int x, input int y, output int k);
        disp_x = crd_t'(x);
        disp_y = crd_t'(y);
        @(negedge clk);
        k = int'(disp_kind);
    endtask

    task automatic scan_board();
        int k;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                read_disp(x, y, k);
                check($sformatf("cell_%0d_%0d", x, y), k, m_board[y][x]);
            end
    endtask

    task automatic occ_query(input string tag);
        int e;
        e = 0;
        for (int i = 0; i < 4; i++) begin
            bus.occ_x[i] = crd_t'(q_x[i]);
            bus.occ_y[i] = crd_t'(q_y[i]);
            if (q_x[i] >= COLS || q_y[i] >= ROWS) e = 1;
            else if (m_board[q_y[i]][q_x[i]] != 0) e = 1;
        end
        @(negedge clk);
        check(tag, int'(bus.occ_hit), e);
    endtask

    task automatic do_clear(input bit with_lock);
        @(negedge clk);
        clear_board    = 1'b1;
        bus.lock_valid = with_lock;
        @(negedge clk);
        clear_board    = 1'b0;
        bus.lock_valid = 1'b0;
        model_clear();
        check("clear_ready", int'(bus.lock_ready), 1);
        check("clear_lines", int'(bus.lines_cleared), 0);
        check("clear_score", int'(score), 0);
    endtask

    task automatic lock_cells(input int kind, input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2, input int x3, input int y3);
        p_x[0] = x0; p_y[0] = y0;
        p_x[1] = x1; p_y[1] = y1;
        p_x[2] = x2; p_y[2] = y2;
        p_x[3] = x3; p_y[3] = y3;
        do_lock(kind);
    endtask

    task automatic four_line_pattern();
        for (int r = 16; r < 20; r++) begin
            lock_cells(4, 0, r, 1, r, 2, r, 3, r);
            lock_cells(7, 4, r, 5, r, 6, r, 7, r);
        end
        lock_cells(1, 8, 16, 8, 17, 8, 18, 8, 19);
        lock_cells(2, 9, 16, 9, 17, 9, 18, 9, 19);
    endtask

    task automatic one_line_pattern();
        lock_cells(3, 0, 19, 1, 19, 2, 19, 3, 19);
        lock_cells(5, 4, 19, 5, 19, 6, 19, 7, 19);
        lock_cells(8, 8, 19, 31, 31, 12, 3, 3, 25);
        lock_cells(9, 9, 19, 31, 0, 0, 31, 10, 10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, a, v, pk, lat_n;
        bit seen;

        reset_n         = 1'b0;
        clear_board     = 1'b0;
        disp_x          = '0;
        disp_y          = '0;
        bus.piece_valid = 1'b0;
        bus.piece_kind  = '0;
        bus.piece_x     = '0;
        bus.piece_y     = '0;
        bus.occ_x       = '0;
        bus.occ_y       = '0;
        bus.lock_valid  = 1'b0;
        model_clear();

        // Saturating BCD adder on its own.
        begin
            int ca [5] = '{9, 9998, 9999, 99, 0};
            int cv [5] = '{1, 4, 7, 1, 0};
            for (int i = 0; i < 25; i++) begin
                if (i < 5) begin a = ca[i]; v = cv[i]; end
                else begin a = $urandom_range(0, 9999); v = $urandom_range(0, 7); end
                bcd_in  = 16'(to_bcd(a));
                bcd_val = 3'(v);
                #1;
                check($sformatf("bcd_%0d_plus_%0d", a, v), int'(bcd_out),
                      to_bcd(a + v > 9999 ? 9999 : a + v));
            end
        end

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("rst_lock_ready", int'(bus.lock_ready), 1);
        check("rst_clear_done", int'(bus.clear_done), 0);
        check("rst_lines", int'(bus.lines_cleared), 0);
        check("rst_score", int'(score), 0);
        check("rst_disp", int'(disp_kind), 0);
        check("rst_occ", int'(bus.occ_hit), 0);
        scan_board();

        q_x = '{0, 1, 2, 3}; q_y = '{0, 1, 2, 3};
        occ_query("occ_empty");
        q_x = '{10, 0, 0, 0}; q_y = '{0, 0, 0, 0};
        occ_query("occ_x10");
        q_x = '{0, 0, 0, 0}; q_y = '{20, 0, 0, 0};
        occ_query("occ_y20");

        // Horizontal piece on the floor, no lines.
        lock_cells(3, 4, 19, 5, 19, 6, 19, 7, 19);
        read_disp(5, 19, k);
        check("disp_5_19", k, 3);
        scan_board();
        q_x = '{0, 1, 2, 6}; q_y = '{0, 0, 0, 19};
        occ_query("occ_piece");

        // One line: floor row filled, column 9 I-piece completes it.
        do_clear(1'b0);
        lock_cells(1, 0, 19, 1, 19, 2, 19, 3, 19);
        lock_cells(2, 4, 19, 5, 19, 6, 19, 7, 19);
        lock_cells(5, 8, 16, 8, 17, 8, 18, 8, 19);
        lock_cells(6, 9, 16, 9, 17, 9, 18, 9, 19);
        check("one_line", m_lines, 1);
        scan_board();

        // Four lines, then score carry 8 -> 9 -> 10.
        do_clear(1'b0);
        four_line_pattern();
        scan_board();
        four_line_pattern();
        one_line_pattern();
        one_line_pattern();
        scan_board();

        // Piece overlay on the display while idle.
        p_x = '{2, 3, 4, 10}; p_y = '{3, 3, 3, 5};
        pk  = 9;
        @(negedge clk);
        set_piece(pk, 1'b1);
        read_disp(3, 3, k);  check("ovl_3_3", k, exp_disp(3, 3, 1, pk));
        read_disp(10, 5, k); check("ovl_10_5", k, exp_disp(10, 5, 1, pk));
        read_disp(5, 3, k);  check("ovl_5_3", k, exp_disp(5, 3, 1, pk));
        read_disp(2, 20, k); check("ovl_2_20", k, 0);
        bus.piece_valid = 1'b0;

        // Lock accepted, then new game mid-scan: back to idle, no done pulse, board empty.
        p_x = '{0, 1, 2, 3}; p_y = '{19, 19, 19, 19};
        @(negedge clk);
        set_piece(2, 1'b1);
        bus.lock_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.lock_valid = 1'b0;
        repeat (5) @(posedge clk);
        do_clear(1'b1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.clear_done) seen = 1;
        end
        check("no_done_after_clear", int'(seen), 0);
        @(negedge clk);
        bus.piece_valid = 1'b0;
        scan_board();

        // New game while idle with lock_valid in the same cycle: lock must be ignored.
        do_clear(1'b1);
        lat_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!bus.lock_ready) lat_n++;
        end
        check("clear_ignores_lock", lat_n, 0);

        // Randomized pieces near the floor, including off-board cells.
        for (int it = 0; it < 30; it++) begin
            pk = $urandom_range(1, 9);
            for (int i = 0; i < 4; i++) begin
                p_x[i] = $urandom_range(0, 11);
                p_y[i] = $urandom_range(15, 21);
            end
            do_lock(pk);
            scan_board();
            for (int j = 0; j < 3; j++) begin
                for (int i = 0; i < 4; i++) begin
                    q_x[i] = $urandom_range(0, 10);
                    q_y[i] = $urandom_range(12, 20);
                end
                occ_query("occ_rand");
            end
            for (int i = 0; i < 4; i++) begin
                p_x[i] = $urandom_range(0, 11);
                p_y[i] = $urandom_range(14, 20);
            end
            set_piece(pk, 1'b1);
            for (int j = 0; j < 4; j++) begin
                a = (j < 2) ? p_x[j] : $urandom_range(0, 11);
                v = (j < 2) ? p_y[j] : $urandom_range(14, 20);
                read_disp(a, v, k);
                check("ovl_rand", k, exp_disp(a, v, 1, pk));
            end
            bus.piece_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
